io_control: RTL and testbench
=============================

Name: io_control

Overview:
- Sequencer for the pixel-stamping datapath (io_datapath). Accepts brush-stamp requests and canvas-clear requests.
- Arbitrates between them and drives the datapath's draw/erase/count_reset controls and base coordinates.
- Generates the framebuffer write strobe (plot) and colour, and signals completion.
- Sits between the input front-end (mouse/keypad decode) and the VGA framebuffer writer.

Parameters:
- BRUSH_W, 10, brush stamp width in pixels (datapath draw x wrap = BRUSH_W-1)
- BRUSH_H, 14, brush stamp height in pixels
- CANVAS_X0, 89, canvas left edge
- CANVAS_Y0, 33, canvas top edge
- CANVAS_W, 140, canvas width (datapath erase x wrap = CANVAS_W-1)
- CANVAS_H, 196, canvas height
- COLOUR_W, 3, framebuffer colour width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- draw_req  in  1  single-cycle pulse: stamp brush at x_req/y_req
- erase_req  in  1  single-cycle pulse: clear whole canvas
- x_req  in  8  requested brush top-left x
- y_req  in  8  requested brush top-left y
- draw_colour  in  COLOUR_W  brush colour, sampled with draw_req
- dp_count_reset  out  1  to datapath count_reset (active-low counter clear)
- dp_draw  out  1  to datapath draw
- dp_erase  out  1  to datapath erase
- dp_x  out  8  to datapath x_in (latched, clamped)
- dp_y  out  8  to datapath y_in (latched, clamped)
- plot  out  1  framebuffer write enable, pixel at datapath x_out/y_out
- colour  out  COLOUR_W  framebuffer write colour
- busy  out  1  high from CLEAR through DONE
- done  out  1  one-cycle pulse after the last pixel of an operation

Behaviour:
- Reset values (asynchronous, held while reset=1):
  - state=IDLE, dp_count_reset=0 (datapath counters held clear)
  - dp_draw=dp_erase=plot=busy=done=0, colour=0
  - dp_x=CANVAS_X0, dp_y=CANVAS_Y0; pending flags cleared
- States: IDLE, CLEAR, DRAW, ERASE, DONE.
- IDLE: dp_count_reset=1. Any pending/arriving request -> CLEAR, with erase taking priority over draw.
- CLEAR, 1 cycle: dp_count_reset=0, no plot. Next state is DRAW or ERASE per the selected operation.
- DRAW: dp_draw=1, plot=1, colour=latched draw_colour.
  - Pixel counter (15 bit) counts 0..BRUSH_W*BRUSH_H-1 = 139.
  - At 139 -> DONE; the datapath counters have wrapped to 0 at that edge.
- ERASE: dp_erase=1, plot=1, colour=0.
  - Counter counts to CANVAS_W*CANVAS_H-1 = 27439, then -> DONE.
- DONE, 1 cycle: done=1, dp_draw=dp_erase=plot=0.
  - Next state is CLEAR if a request is pending, else IDLE.
- Latency: draw_req sampled at edge N gives CLEAR in cycle N+1 and plot high for cycles N+2..N+141. done is high in N+142; busy is high N+1..N+142.
- dp_draw and dp_erase are never high together. plot is high exactly when one of them is high.
- Request capture:
  - Pulses are captured into pending flags every cycle, including while busy.
  - Draw captures x/y/colour into a one-deep pending slot. A later draw_req overwrites it (latest wins).
  - An erase_req while an erase is pending or active is merged (no extra erase).
  - A draw pending at erase start is kept and executed after the erase.
  - Simultaneous draw_req and erase_req: both are captured, erase runs first.
- Coordinate clamp (8-bit, applied at capture):
  - dp_x = min(max(x_req, CANVAS_X0), CANVAS_X0+CANVAS_W-BRUSH_W) = [89, 219].
  - dp_y = min(max(y_req, CANVAS_Y0), CANVAS_Y0+CANVAS_H-BRUSH_H) = [33, 215].
  - dp_x/dp_y are loaded only on entering CLEAR and stay stable for the whole operation.
- Reset mid-operation: an immediate return to reset values. The partial operation is abandoned; no done pulse is produced.

Decomposition:
- Package io_pkg holds:
  - the state enum (IDLE, CLEAR, DRAW, ERASE, DONE)
  - geometry constants and derived limits: BRUSH_PIX=140, CANVAS_PIX=27440, X_MAX=219, Y_MAX=215
  - the pixel-counter width (15)
- Sub-module io_req_latch: holds the pending draw slot (flag, clamped x/y, colour) and the pending erase flag. It performs clamp and overwrite/merge and exposes a pop input driven from the FSM.

Test Plan:
- Draw at (100,50), colour 3'b111 → CLEAR one cycle later, then 140 plot cycles with dp_x=100, dp_y=50, colour=7, then a single done pulse and return to IDLE; busy is high for 142 cycles.
- Erase request → 27440 plot cycles with colour=0 and dp_erase=1, dp_draw=0 throughout, then done.
- draw_req at (10,250) → dp_x=89, dp_y=215; draw_req at (230,20) → dp_x=219, dp_y=33.
- During a draw, issue draw_req (120,60) then draw_req (130,70) → after the first done, exactly one more draw at (130,70).
- Simultaneous draw_req (100,100) and erase_req in IDLE → erase runs first, then the draw; a second erase_req mid-erase adds no extra erase.
- Assert reset at pixel 70 of a draw → outputs at reset values immediately with no done; after release, a new draw_req produces a full 140-pixel stamp.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: geometry constants, FSM states and clamp helper for the pixel-stamping sequencer
package io_pkg;
  localparam int BRUSH_W    = 10;
  localparam int BRUSH_H    = 14;
  localparam int CANVAS_X0  = 89;
  localparam int CANVAS_Y0  = 33;
  localparam int CANVAS_W   = 140;
  localparam int CANVAS_H   = 196;
  localparam int COLOUR_W   = 3;
  localparam int BRUSH_PIX  = BRUSH_W * BRUSH_H;
  localparam int CANVAS_PIX = CANVAS_W * CANVAS_H;
  localparam int X_MAX      = CANVAS_X0 + CANVAS_W - BRUSH_W;
  localparam int Y_MAX      = CANVAS_Y0 + CANVAS_H - BRUSH_H;
  localparam int CNT_W      = 15;

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, ERASE, DONE} state_t;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input int lo, input int hi);
    return (int'(v) < lo) ? 8'(lo) : (int'(v) > hi) ? 8'(hi) : v;
  endfunction
endpackage

// File: rtl/io_if.sv
// io_if: request inputs and datapath/framebuffer controls of the stamping sequencer
interface io_if;
  import io_pkg::*;
  logic                draw_req;
  logic                erase_req;
  logic [7:0]          x_req;
  logic [7:0]          y_req;
  logic [COLOUR_W-1:0] draw_colour;
  logic                dp_count_reset;
  logic                dp_draw;
  logic                dp_erase;
  logic [7:0]          dp_x;
  logic [7:0]          dp_y;
  logic                plot;
  logic [COLOUR_W-1:0] colour;
  logic                busy;
  logic                done;
  modport slave (
    input  draw_req, erase_req, x_req, y_req, draw_colour,
    output dp_count_reset, dp_draw, dp_erase, dp_x, dp_y, plot, colour, busy, done
  );
  modport master (
    output draw_req, erase_req, x_req, y_req, draw_colour,
    input  dp_count_reset, dp_draw, dp_erase, dp_x, dp_y, plot, colour, busy, done
  );
endinterface

// File: rtl/io_req_latch.sv
// io_req_latch: pending draw slot (latest wins, clamped) and merged pending erase flag
module io_req_latch
  import io_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                draw_req,
  input  logic                erase_req,
  input  logic [7:0]          x_req,
  input  logic [7:0]          y_req,
  input  logic [COLOUR_W-1:0] draw_colour,
  input  logic                pop_draw,
  input  logic                pop_erase,
  input  logic                erase_busy,
  output logic                draw_pend,
  output logic                erase_pend,
  output logic [7:0]          pend_x,
  output logic [7:0]          pend_y,
  output logic [COLOUR_W-1:0] pend_colour
);
  logic                d_q, e_q;
  logic [7:0]          x_q, y_q, x_c, y_c;
  logic [COLOUR_W-1:0] c_q;
  assign x_c = clamp8(x_req, CANVAS_X0, X_MAX);
  assign y_c = clamp8(y_req, CANVAS_Y0, Y_MAX);
  // arriving pulses are visible the same cycle so an idle sequencer can start at once
  assign draw_pend   = draw_req | d_q;
  assign erase_pend  = (erase_req & ~erase_busy) | e_q;
  assign pend_x      = draw_req ? x_c : x_q;
  assign pend_y      = draw_req ? y_c : y_q;
  assign pend_colour = draw_req ? draw_colour : c_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
      e_q <= 1'b0;
      x_q <= 8'(CANVAS_X0);
      y_q <= 8'(CANVAS_Y0);
      c_q <= '0;
    end else begin
      d_q <= draw_pend & ~pop_draw;
      e_q <= erase_pend & ~pop_erase;
      if (draw_req) begin
        x_q <= x_c;
        y_q <= y_c;
        c_q <= draw_colour;
      end
    end
  end
endmodule

// File: rtl/io_control.sv
// io_control: arbitrates stamp/clear requests and sequences the pixel datapath and framebuffer strobe
module io_control
  import io_pkg::*;
(
  input logic clock,
  input logic reset,
  io_if.slave bus
);
  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                op_erase, cr_q, start, last, pop_draw, pop_erase, erase_busy;
  logic                draw_pend, erase_pend;
  logic [7:0]          x_q, y_q, pend_x, pend_y;
  logic [COLOUR_W-1:0] col_q, pend_colour;

  io_req_latch u_latch (
    .clock       (clock),
    .reset       (reset),
    .draw_req    (bus.draw_req),
    .erase_req   (bus.erase_req),
    .x_req       (bus.x_req),
    .y_req       (bus.y_req),
    .draw_colour (bus.draw_colour),
    .pop_draw    (pop_draw),
    .pop_erase   (pop_erase),
    .erase_busy  (erase_busy),
    .draw_pend   (draw_pend),
    .erase_pend  (erase_pend),
    .pend_x      (pend_x),
    .pend_y      (pend_y),
    .pend_colour (pend_colour)
  );

  assign start = (state == IDLE || state == DONE) && (draw_pend || erase_pend);
  assign last  = (state == DRAW && cnt == CNT_W'(BRUSH_PIX - 1)) ||
                 (state == ERASE && cnt == CNT_W'(CANVAS_PIX - 1));

  always_comb begin
    state_n    = IDLE;
    pop_erase  = start && erase_pend;
    pop_draw   = start && !erase_pend;
    erase_busy = (state == CLEAR && op_erase) || state == ERASE;
    case (state)
      IDLE, DONE:  state_n = start ? CLEAR : IDLE;
      CLEAR:       state_n = op_erase ? ERASE : DRAW;
      DRAW, ERASE: state_n = last ? DONE : state;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_erase <= 1'b0;
      cr_q     <= 1'b0;
      x_q      <= 8'(CANVAS_X0);
      y_q      <= 8'(CANVAS_Y0);
      col_q    <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n == state && (state == DRAW || state == ERASE)) ? cnt + 1'b1 : '0;
      // counters are cleared only during the one-cycle CLEAR step
      cr_q  <= state_n != CLEAR;
      if (start) begin
        op_erase <= erase_pend;
        x_q      <= erase_pend ? 8'(CANVAS_X0) : pend_x;
        y_q      <= erase_pend ? 8'(CANVAS_Y0) : pend_y;
        col_q    <= pend_colour;
      end
    end
  end

  assign bus.dp_count_reset = cr_q;
  assign bus.dp_draw        = state == DRAW;
  assign bus.dp_erase       = state == ERASE;
  assign bus.plot           = state == DRAW || state == ERASE;
  assign bus.colour         = state == DRAW ? col_q : '0;
  assign bus.busy           = state != IDLE;
  assign bus.done           = state == DONE;
  assign bus.dp_x           = x_q;
  assign bus.dp_y           = y_q;
endmodule

// File: tb/tb_io_control.sv
// tb_io_control: randomized self-checking bench for io_control against a clamp/pending-request model
module tb_io_control;
  import io_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  io_if bus();
  io_control dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;

  int nchk = 0, nerr = 0, busy_cycles = 0, done_cnt = 0;

  always @(posedge clock) begin
    #1;
    if (bus.busy) busy_cycles++;
    if (bus.done) done_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_clamp(input int v, input int lo, input int hi);
    return 8'(v < lo ? lo : v > hi ? hi : v);
  endfunction

  task automatic pulse(input logic d, input logic e, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    @(negedge clock);
    bus.draw_req = d; bus.erase_req = e; bus.x_req = x; bus.y_req = y; bus.draw_colour = c;
    @(negedge clock);
    bus.draw_req = 1'b0; bus.erase_req = 1'b0;
    bus.x_req = 8'($urandom); bus.y_req = 8'($urandom); bus.draw_colour = 3'($urandom);
  endtask

  // measures one operation: plot length, coordinates, colour and whether it stayed consistent
  task automatic observe(output int len, output logic [7:0] ox, output logic [7:0] oy,
                         output logic [2:0] oc, output logic oe, output logic ok, output logic dn);
    int t = 0;
    len = 0; ox = 0; oy = 0; oc = 0; oe = 0; ok = 1'b1; dn = 1'b0;
    while (!bus.plot && t < 200) begin @(negedge clock); t++; end
    if (!bus.plot) return;
    ox = bus.dp_x; oy = bus.dp_y; oc = bus.colour; oe = bus.dp_erase;
    while (bus.plot && len < 30000) begin
      if (bus.dp_x !== ox || bus.dp_y !== oy || bus.colour !== oc || bus.dp_erase !== oe ||
          bus.dp_draw !== !oe || bus.dp_count_reset !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0)
        ok = 1'b0;
      len++;
      @(negedge clock);
    end
    dn = bus.done;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    nchk++;
    if ({bus.dp_count_reset, bus.dp_draw, bus.dp_erase, bus.plot, bus.busy, bus.done, bus.colour, bus.dp_x, bus.dp_y}
        !== {6'b0, 3'd0, 8'd89, 8'd33}) begin
      nerr++;
      $display("FAIL reset_values: cr=%0b draw=%0b erase=%0b plot=%0b busy=%0b done=%0b col=%0d x=%0d y=%0d, expected all 0 x=89 y=33",
               bus.dp_count_reset, bus.dp_draw, bus.dp_erase, bus.plot, bus.busy, bus.done, bus.colour, bus.dp_x, bus.dp_y);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    nchk++;
    if ({bus.dp_count_reset, bus.busy, bus.plot} !== 3'b100) begin
      nerr++;
      $display("FAIL idle_after_reset: cr=%0b busy=%0b plot=%0b, expected 1 0 0", bus.dp_count_reset, bus.busy, bus.plot);
    end
  endtask

  task automatic test_draw;
    int len, d0; logic [7:0] ox, oy; logic [2:0] oc; logic oe, ok, dn;
    busy_cycles = 0; d0 = done_cnt;
    pulse(1'b1, 1'b0, 8'd100, 8'd50, 3'd7);
    nchk++;
    if ({bus.busy, bus.plot, bus.dp_count_reset, bus.dp_x, bus.dp_y} !== {3'b100, 8'd100, 8'd50}) begin
      nerr++;
      $display("FAIL draw_clear_cycle: busy=%0b plot=%0b cr=%0b x=%0d y=%0d, expected 1 0 0 100 50",
               bus.busy, bus.plot, bus.dp_count_reset, bus.dp_x, bus.dp_y);
    end
    observe(len, ox, oy, oc, oe, ok, dn);
    nchk++;
    if (len !== BRUSH_PIX || ox !== 8'd100 || oy !== 8'd50 || oc !== 3'd7 || oe !== 1'b0 || !ok || !dn) begin
      nerr++;
      $display("FAIL draw_op: len=%0d x=%0d y=%0d col=%0d erase=%0b ok=%0b done=%0b, expected 140 100 50 7 0 1 1",
               len, ox, oy, oc, oe, ok, dn);
    end
    @(negedge clock);
    nchk++;
    if ({bus.busy, bus.dp_count_reset, bus.done} !== 3'b010) begin
      nerr++;
      $display("FAIL draw_return_idle: busy=%0b cr=%0b done=%0b, expected 0 1 0", bus.busy, bus.dp_count_reset, bus.done);
    end
    nchk++;
    if (busy_cycles !== 142 || done_cnt - d0 !== 1) begin
      nerr++;
      $display("FAIL draw_busy_done: busy_cycles=%0d done_pulses=%0d, expected 142 1", busy_cycles, done_cnt - d0);
    end
  endtask

  task automatic test_erase;
    int len; logic [7:0] ox, oy; logic [2:0] oc; logic oe, ok, dn;
    pulse(1'b0, 1'b1, 8'd0, 8'd0, 3'd5);
    observe(len, ox, oy, oc, oe, ok, dn);
    nchk++;
    if (len !== CANVAS_PIX || oc !== 3'd0 || oe !== 1'b1 || !ok || !dn) begin
      nerr++;
      $display("FAIL erase_op: len=%0d col=%0d erase=%0b ok=%0b done=%0b, expected 27440 0 1 1 1", len, oc, oe, ok, dn);
    end
  endtask

  task automatic test_clamp;
    int xs[8] = '{10, 230, 89, 88, 219, 220, 0, 255};
    int ys[8] = '{250, 20, 33, 32, 215, 216, 255, 0};
    int len; logic [7:0] ox, oy; logic [2:0] oc; logic oe, ok, dn;
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 1'b0, 8'(xs[i]), 8'(ys[i]), 3'(i));
      observe(len, ox, oy, oc, oe, ok, dn);
      nchk++;
      if (ox !== ref_clamp(xs[i], CANVAS_X0, X_MAX) || oy !== ref_clamp(ys[i], CANVAS_Y0, Y_MAX) ||
          len !== BRUSH_PIX || oc !== 3'(i) || !ok || !dn) begin
        nerr++;
        $display("FAIL clamp_%0d: in=(%0d,%0d) got x=%0d y=%0d len=%0d col=%0d, expected x=%0d y=%0d len=140 col=%0d",
                 i, xs[i], ys[i], ox, oy, len, oc, ref_clamp(xs[i], CANVAS_X0, X_MAX), ref_clamp(ys[i], CANVAS_Y0, Y_MAX), i);
      end
    end
  endtask

  task automatic test_overwrite;
    int l1, l2, l3; logic [7:0] x1, y1, x2, y2, x3, y3; logic [2:0] c1, c2, c3;
    logic e1, e2, e3, k1, k2, k3, d1, d2, d3;
    pulse(1'b1, 1'b0, 8'd150, 8'd80, 3'd2);
    fork
      observe(l1, x1, y1, c1, e1, k1, d1);
      begin
        repeat (20) @(negedge clock);
        pulse(1'b1, 1'b0, 8'd120, 8'd60, 3'd5);
        repeat (30) @(negedge clock);
        pulse(1'b1, 1'b0, 8'd130, 8'd70, 3'd6);
      end
    join
    nchk++;
    if (l1 !== BRUSH_PIX || x1 !== 8'd150 || y1 !== 8'd80 || c1 !== 3'd2 || !k1 || !d1) begin
      nerr++;
      $display("FAIL overwrite_first: len=%0d x=%0d y=%0d col=%0d, expected 140 150 80 2", l1, x1, y1, c1);
    end
    observe(l2, x2, y2, c2, e2, k2, d2);
    nchk++;
    if (l2 !== BRUSH_PIX || x2 !== 8'd130 || y2 !== 8'd70 || c2 !== 3'd6 || e2 !== 1'b0 || !k2 || !d2) begin
      nerr++;
      $display("FAIL overwrite_latest: len=%0d x=%0d y=%0d col=%0d, expected 140 130 70 6", l2, x2, y2, c2);
    end
    observe(l3, x3, y3, c3, e3, k3, d3);
    nchk++;
    if (l3 !== 0) begin
      nerr++;
      $display("FAIL overwrite_no_extra: extra op len=%0d at x=%0d y=%0d, expected none", l3, x3, y3);
    end
  endtask

  task automatic test_simul;
    int l1, l2, l3; logic [7:0] x1, y1, x2, y2, x3, y3; logic [2:0] c1, c2, c3;
    logic e1, e2, e3, k1, k2, k3, d1, d2, d3;
    pulse(1'b1, 1'b1, 8'd100, 8'd100, 3'd4);
    fork
      observe(l1, x1, y1, c1, e1, k1, d1);
      begin
        repeat (1000) @(negedge clock);
        pulse(1'b0, 1'b1, 8'd0, 8'd0, 3'd0);
      end
    join
    nchk++;
    if (l1 !== CANVAS_PIX || e1 !== 1'b1 || c1 !== 3'd0 || !k1 || !d1) begin
      nerr++;
      $display("FAIL simul_erase_first: len=%0d erase=%0b col=%0d, expected 27440 1 0", l1, e1, c1);
    end
    observe(l2, x2, y2, c2, e2, k2, d2);
    nchk++;
    if (l2 !== BRUSH_PIX || e2 !== 1'b0 || x2 !== 8'd100 || y2 !== 8'd100 || c2 !== 3'd4 || !k2 || !d2) begin
      nerr++;
      $display("FAIL simul_draw_after: len=%0d erase=%0b x=%0d y=%0d col=%0d, expected 140 0 100 100 4", l2, e2, x2, y2, c2);
    end
    observe(l3, x3, y3, c3, e3, k3, d3);
    nchk++;
    if (l3 !== 0) begin
      nerr++;
      $display("FAIL simul_merged_erase: extra op len=%0d erase=%0b, expected none", l3, e3);
    end
  endtask

  task automatic test_reset_mid;
    int t = 0, d0, len; logic [7:0] ox, oy, rx, ry; logic [2:0] oc; logic oe, ok, dn;
    pulse(1'b1, 1'b0, 8'd180, 8'd120, 3'd3);
    while (!bus.plot && t < 10) begin @(negedge clock); t++; end
    repeat (10) @(negedge clock);
    pulse(1'b1, 1'b0, 8'd90, 8'd90, 3'd1);
    repeat (58) @(negedge clock);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    nchk++;
    if ({bus.dp_count_reset, bus.dp_draw, bus.dp_erase, bus.plot, bus.busy, bus.done, bus.colour, bus.dp_x, bus.dp_y}
        !== {6'b0, 3'd0, 8'd89, 8'd33}) begin
      nerr++;
      $display("FAIL reset_mid_values: cr=%0b draw=%0b plot=%0b busy=%0b done=%0b col=%0d x=%0d y=%0d, expected all 0 x=89 y=33",
               bus.dp_count_reset, bus.dp_draw, bus.plot, bus.busy, bus.done, bus.colour, bus.dp_x, bus.dp_y);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    observe(len, ox, oy, oc, oe, ok, dn);
    nchk++;
    if (len !== 0 || done_cnt !== d0) begin
      nerr++;
      $display("FAIL reset_mid_abandon: op len=%0d done_pulses=%0d after reset, expected 0 0", len, done_cnt - d0);
    end
    rx = 8'($urandom); ry = 8'($urandom);
    pulse(1'b1, 1'b0, rx, ry, 3'd6);
    observe(len, ox, oy, oc, oe, ok, dn);
    nchk++;
    if (len !== BRUSH_PIX || ox !== ref_clamp(rx, CANVAS_X0, X_MAX) || oy !== ref_clamp(ry, CANVAS_Y0, Y_MAX) || !ok || !dn) begin
      nerr++;
      $display("FAIL reset_mid_restart: len=%0d x=%0d y=%0d, expected 140 %0d %0d",
               len, ox, oy, ref_clamp(rx, CANVAS_X0, X_MAX), ref_clamp(ry, CANVAS_Y0, Y_MAX));
    end
  endtask

  task automatic test_random;
    int l1, l2, extra, fx, fy, lx, ly; logic [2:0] fc, lc;
    logic [7:0] x1, y1, x2, y2; logic [2:0] c1, c2; logic e1, e2, k1, k2, d1, d2;
    for (int i = 0; i < 6; i++) begin
      fx = $urandom_range(0, 255); fy = $urandom_range(0, 255); fc = 3'($urandom);
      extra = $urandom_range(0, 2);
      lx = fx; ly = fy; lc = fc;
      pulse(1'b1, 1'b0, 8'(fx), 8'(fy), fc);
      fork
        observe(l1, x1, y1, c1, e1, k1, d1);
        for (int k = 0; k < extra; k++) begin
          repeat ($urandom_range(1, 50)) @(negedge clock);
          lx = $urandom_range(0, 255); ly = $urandom_range(0, 255); lc = 3'($urandom);
          pulse(1'b1, 1'b0, 8'(lx), 8'(ly), lc);
        end
      join
      nchk++;
      if (l1 !== BRUSH_PIX || x1 !== ref_clamp(fx, CANVAS_X0, X_MAX) || y1 !== ref_clamp(fy, CANVAS_Y0, Y_MAX) ||
          c1 !== fc || !k1 || !d1) begin
        nerr++;
        $display("FAIL random_%0d_first: len=%0d x=%0d y=%0d col=%0d, expected 140 %0d %0d %0d",
                 i, l1, x1, y1, c1, ref_clamp(fx, CANVAS_X0, X_MAX), ref_clamp(fy, CANVAS_Y0, Y_MAX), fc);
      end
      observe(l2, x2, y2, c2, e2, k2, d2);
      nchk++;
      if (extra == 0 ? (l2 !== 0) :
          (l2 !== BRUSH_PIX || x2 !== ref_clamp(lx, CANVAS_X0, X_MAX) || y2 !== ref_clamp(ly, CANVAS_Y0, Y_MAX) ||
           c2 !== lc || !k2 || !d2)) begin
        nerr++;
        $display("FAIL random_%0d_pending: extra=%0d len=%0d x=%0d y=%0d col=%0d, expected len=%0d x=%0d y=%0d col=%0d",
                 i, extra, l2, x2, y2, c2, extra == 0 ? 0 : BRUSH_PIX,
                 ref_clamp(lx, CANVAS_X0, X_MAX), ref_clamp(ly, CANVAS_Y0, Y_MAX), lc);
      end
      if (extra != 0) begin
        observe(l2, x2, y2, c2, e2, k2, d2);
        nchk++;
        if (l2 !== 0) begin
          nerr++;
          $display("FAIL random_%0d_no_extra: extra op len=%0d, expected none", i, l2);
        end
      end
    end
  endtask

  initial begin
    bus.draw_req = 1'b0; bus.erase_req = 1'b0;
    bus.x_req = 8'd0; bus.y_req = 8'd0; bus.draw_colour = 3'd0;
    test_reset;
    test_draw;
    test_erase;
    test_clamp;
    test_overwrite;
    test_simul;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
